multichannel_decimator: RTL

// Per-channel decimator for interleaved AXI-stream sample flows in the signal chain.

---
 rtl/multichannel_decimator.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/multichannel_decimator.sv
// Per-channel decimator for interleaved AXI-stream samples. Each channel
// emits one result per 2^ratio_log2 accepted samples: the last sample of
// the window or its exact (floor) average. Output is held until accepted.

// Per-channel window state: accumulator and sample counter.
module mcd_chan #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_RATIO_LOG2 = 4,
  parameter int RW             = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         hit_i,     // sample accepted for this channel
  input  logic                         clr_i,     // config changed: restart window
  input  logic [RW-1:0]                ratio_i,   // already clamped
  input  logic                         avg_en_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  output logic                         done_o,    // this sample closes the window
  output logic [DATA_WIDTH-1:0]        res_o
);
  localparam int AW = DATA_WIDTH + MAX_RATIO_LOG2;
  localparam int CW = MAX_RATIO_LOG2;

  logic signed [AW-1:0] acc_q, acc_d, acc_base, sum;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_base, cnt_last;

  // Window arithmetic; a config change makes this sample the first of a new window.
  always_comb begin
    acc_base = clr_i ? '0 : acc_q;
    cnt_base = clr_i ? '0 : cnt_q;
    cnt_last = CW'((32'd1 << ratio_i) - 32'd1);
    sum      = acc_base + {{MAX_RATIO_LOG2{sample_i[DATA_WIDTH-1]}}, sample_i};
    done_o   = hit_i & (cnt_base == cnt_last);
    res_o    = avg_en_i ? DATA_WIDTH'(sum >>> ratio_i) : sample_i;
    acc_d    = acc_base;
    cnt_d    = cnt_base;
    if (hit_i) begin
      if (done_o) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  // Window state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module multichannel_decimator #(
  parameter int N_CHANNELS     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int DEST_WIDTH     = 8,
  parameter int MAX_RATIO_LOG2 = 4,
  localparam int RW            = $clog2(MAX_RATIO_LOG2 + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in_data_i,
  input  logic [DEST_WIDTH-1:0] data_in_dest_i,
  input  logic                  data_in_valid_i,
  output logic                  data_in_ready_o,
  output logic [DATA_WIDTH-1:0] data_out_data_o,
  output logic [DEST_WIDTH-1:0] data_out_dest_o,
  output logic                  data_out_valid_o,
  input  logic                  data_out_ready_i,
  input  logic [RW-1:0]         ratio_log2_i,
  input  logic                  average_en_i,
  output logic                  dest_error_o
);
  logic [RW-1:0]                          ratio_q, ratio_eff;
  logic                                   avg_q, cfg_chg, xfer, dest_ok, any_done;
  logic [N_CHANNELS-1:0]                  hit, done;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0]  res;
  logic [DATA_WIDTH-1:0]                  res_sel;
  logic                                   valid_q, valid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0]                  data_q, data_d;
  logic [DEST_WIDTH-1:0]                  dest_q, dest_d;

  // A single output register stalls all channels while a result is pending.
  assign data_in_ready_o = ~valid_q | data_out_ready_i;
  assign xfer            = data_in_valid_i & data_in_ready_o;
  assign dest_ok         = data_in_dest_i < DEST_WIDTH'(N_CHANNELS);
  assign ratio_eff       = (ratio_log2_i > RW'(MAX_RATIO_LOG2)) ? RW'(MAX_RATIO_LOG2) : ratio_log2_i;
  assign cfg_chg         = (ratio_log2_i != ratio_q) | (average_en_i != avg_q);

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
    assign hit[g] = xfer & (data_in_dest_i == DEST_WIDTH'(g));
    mcd_chan #(
      .DATA_WIDTH    (DATA_WIDTH),
      .MAX_RATIO_LOG2(MAX_RATIO_LOG2),
      .RW            (RW)
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .hit_i   (hit[g]),
      .clr_i   (cfg_chg),
      .ratio_i (ratio_eff),
      .avg_en_i(average_en_i),
      .sample_i(data_in_data_i),
      .done_o  (done[g]),
      .res_o   (res[g])
    );
  end

  // Output next-state: a new result wins over draining, so no bubble on back-to-back.
  always_comb begin
    any_done = 1'b0;
    res_sel  = '0;
    for (int ch = 0; ch < N_CHANNELS; ch++) begin
      if (done[ch]) begin
        any_done = 1'b1;
        res_sel  = res[ch];
      end
    end
    valid_d = valid_q;
    data_d  = data_q;
    dest_d  = dest_q;
    err_d   = xfer & ~dest_ok;
    if (any_done) begin
      valid_d = 1'b1;
      data_d  = res_sel;
      dest_d  = data_in_dest_i;
    end else if (data_out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output, error pulse and config registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dest_q  <= '0;
      err_q   <= 1'b0;
      ratio_q <= '0;
      avg_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      err_q   <= err_d;
      ratio_q <= ratio_log2_i;
      avg_q   <= average_en_i;
    end
  end

  assign data_out_valid_o = valid_q;
  assign data_out_data_o  = data_q;
  assign data_out_dest_o  = dest_q;
  assign dest_error_o     = err_q;
endmodule
